// File: rtl/legv8_boot_pkg.sv
// legv8_boot_pkg: boot sequencer states, protocol bytes and a busy helper.
// Shared by the boot sequencer top and its idle timer.
package legv8_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_ACK,
    ST_RUN
  } boot_state_e;

  localparam logic [7:0] BOOT_SYNC = 8'h55;
  localparam logic [7:0] BOOT_ACK  = 8'h06;
  localparam logic [7:0] BOOT_NAK  = 8'h15;

  function automatic logic is_busy(boot_state_e s);
    return s inside {ST_LEN, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/boot_idle_timer.sv
// boot_idle_timer: counts idle cycles while enabled, flags the last one.
// Holds its count when disabled; clear has priority over counting.
module boot_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expired)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/legv8_boot_sequencer.sv
// legv8_boot_sequencer: UART frame loader for IMEM, gates core_run.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module legv8_boot_sequencer
  import legv8_boot_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  imem_write_en,
  output logic [ADDR_WIDTH-1:0] imem_write_addr,
  output logic [31:0]           imem_write_data,
  output logic                  core_run,
  output logic                  boot_busy
);

  localparam int NW = ADDR_WIDTH + 1;
  localparam int unsigned CAP = 1 << ADDR_WIDTH;

  boot_state_e state_q, state_d;
  logic [7:0]            tx_q, tx_d;
  logic [NW-1:0]         n_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            lane_q;
  logic [23:0]           buf_q;
  logic [31:0]           word_q;
  logic                  wr_q;
  logic len_ok, last_wr, data_byte;
  logic expired, tmr_clear, busy_q;

  assign busy_q  = is_busy(state_q);
  assign len_ok  = (rx_data != 8'd0) && (32'(rx_data) <= CAP);
  assign last_wr = wr_q && ((NW'(idx_q) + NW'(1)) == n_q);
  // a byte landing on the final write pulse is never image data
  assign data_byte = rx_valid && (state_q == ST_DATA) && !last_wr;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       csum_ok;
  assign csum_ok = (rx_data == xor_q);
`endif

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    unique case (state_q)
      ST_IDLE:
        if (rx_valid && rx_data == BOOT_SYNC) state_d = ST_LEN;
      ST_LEN:
        if (rx_valid) begin
          state_d = len_ok ? ST_DATA : ST_ACK;
          if (!len_ok) tx_d = BOOT_NAK;
        end else if (expired) begin
          state_d = ST_ACK;
          tx_d    = BOOT_NAK;
        end
      ST_DATA:
        if (last_wr) begin
`ifdef BOOT_CHECKSUM_EN
          if (rx_valid) begin
            state_d = ST_ACK;
            tx_d    = csum_ok ? BOOT_ACK : BOOT_NAK;
          end else begin
            state_d = ST_CSUM;
          end
`else
          state_d = ST_ACK;
          tx_d    = BOOT_ACK;
`endif
        end else if (expired && !rx_valid) begin
          state_d = ST_ACK;
          tx_d    = BOOT_NAK;
        end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM:
        if (rx_valid) begin
          state_d = ST_ACK;
          tx_d    = csum_ok ? BOOT_ACK : BOOT_NAK;
        end else if (expired) begin
          state_d = ST_ACK;
          tx_d    = BOOT_NAK;
        end
`endif
      ST_ACK:
        if (tx_ready)
          state_d = (tx_q == BOOT_ACK) ? ST_RUN : ST_IDLE;
      ST_RUN:
        if (rx_valid && rx_data == BOOT_SYNC) state_d = ST_LEN;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_q    <= '0;
      idx_q  <= '0;
      lane_q <= '0;
      buf_q  <= '0;
      word_q <= '0;
      wr_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      xor_q  <= '0;
`endif
    end else begin
      wr_q <= 1'b0;
      if (wr_q) idx_q <= idx_q + ADDR_WIDTH'(1);
      if (state_q == ST_LEN && rx_valid && len_ok) begin
        n_q    <= NW'(rx_data);
        idx_q  <= '0;
        lane_q <= '0;
`ifdef BOOT_CHECKSUM_EN
        xor_q  <= '0;
`endif
      end
      if (data_byte) begin
        lane_q <= lane_q + 2'd1;
        buf_q  <= {rx_data, buf_q[23:8]};
`ifdef BOOT_CHECKSUM_EN
        xor_q  <= xor_q ^ rx_data;
`endif
        if (lane_q == 2'd3) begin
          word_q <= {rx_data, buf_q};
          wr_q   <= 1'b1;
        end
      end
    end
  end

  assign tmr_clear = (busy_q && rx_valid) ||
                     (state_d != state_q && is_busy(state_d));

  boot_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (busy_q),
    .expired(expired)
  );

  assign tx_valid        = (state_q == ST_ACK);
  assign tx_data         = tx_q;
  assign imem_write_en   = wr_q;
  assign imem_write_addr = idx_q;
  assign imem_write_data = word_q;
  assign core_run        = (state_q == ST_RUN);
  assign boot_busy       = busy_q;

endmodule

// File: tb/tb_legv8_boot_sequencer.sv
// tb_legv8_boot_sequencer: randomized frames checked against a frame model.
// Define BOOT_CHECKSUM_EN to exercise the checksum variant.
module tb_legv8_boot_sequencer;
  import legv8_boot_pkg::*;

  localparam int AW = 6;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic tx_ready = 1'b0;
  logic tx_valid, imem_write_en, core_run, boot_busy;
  logic [7:0] tx_data;
  logic [AW-1:0] imem_write_addr;
  logic [31:0] imem_write_data;

  int n_tests = 0;
  int n_fail = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  legv8_boot_sequencer #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .imem_write_en(imem_write_en),
    .imem_write_addr(imem_write_addr),
    .imem_write_data(imem_write_data),
    .core_run(core_run),
    .boot_busy(boot_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (imem_write_en) begin
      wa_q.push_back(imem_write_addr);
      wd_q.push_back(imem_write_data);
      chk("no_wr_in_run", 32'(core_run), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic respond(input string tag, input logic [7:0] exp_b,
                         input int hold);
    int w = 0;
    while (!tx_valid && w < 2000) begin
      tick();
      w++;
    end
    chk({tag, "_txv"}, 32'(tx_valid), 32'd1);
    if (tx_valid) begin
      for (int i = 0; i < hold; i++) begin
        chk({tag, "_hold_v"}, 32'(tx_valid), 32'd1);
        chk({tag, "_hold_d"}, 32'(tx_data), 32'(exp_b));
        tick();
      end
      chk({tag, "_resp"}, 32'(tx_data), 32'(exp_b));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk({tag, "_txv_off"}, 32'(tx_valid), 32'd0);
      chk({tag, "_run"}, 32'(core_run), 32'(exp_b == BOOT_ACK));
    end
  endtask

  task automatic check_writes(input string tag, input logic [31:0] exp_w[$]);
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < wa_q.size(); k++) begin
      chk({tag, "_addr"}, 32'(wa_q[k]), 32'(k));
      chk({tag, "_data"}, wd_q[k], exp_w[k]);
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  // bad_cs corrupts the checksum, or appends a stray byte without checksums
  task automatic load_frame(input string tag, input int n, input bit seq,
                            input int gmax, input bit bad_cs,
                            input int hold, input bit with_sync);
    logic [31:0] w[$];
    logic [31:0] wd;
    logic [7:0] x;
    logic [7:0] nb;
    bit ok;
    x  = 8'h00;
    ok = 1'b1;
    nb = 8'(n);
    if (with_sync) send(BOOT_SYNC, $urandom_range(0, gmax));
    send(nb, $urandom_range(0, gmax));
    for (int k = 0; k < n; k++) begin
      wd = seq ? 32'(k) : $urandom();
      w.push_back(wd);
      for (int b = 0; b < 4; b++) begin
        x = x ^ wd[8*b +: 8];
        send(wd[8*b +: 8], (k == n - 1 && b == 3) ? 0 : $urandom_range(0, gmax));
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send(bad_cs ? (x ^ 8'hA5) : x, 0);
    ok = !bad_cs;
`else
    if (bad_cs) send(x ^ 8'hA5, 0);
`endif
    respond(tag, ok ? BOOT_ACK : BOOT_NAK, hold);
    check_writes(tag, w);
  endtask

  task automatic bad_len(input string tag, input logic [7:0] len);
    logic [31:0] none[$];
    send(BOOT_SYNC, 1);
    send(len, 0);
    respond(tag, BOOT_NAK, 1);
    chk({tag, "_busy"}, 32'(boot_busy), 32'd0);
    check_writes(tag, none);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_w[$];
    logic [31:0] none[$];
    logic [7:0] j;
    int c;

    repeat (3) tick();
    chk("rst_run", 32'(core_run), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_wen", 32'(imem_write_en), 32'd0);
    chk("rst_addr", 32'(imem_write_addr), 32'd0);
    chk("rst_wdata", imem_write_data, 32'd0);
    chk("rst_busy", 32'(boot_busy), 32'd0);
    rst = 1'b1;
    tick();

    send(8'h55, 0);
    send(8'h01, 0);
    send(8'h78, 0);
    send(8'h56, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    chk("one_wen", 32'(imem_write_en), 32'd1);
    chk("one_addr", 32'(imem_write_addr), 32'd0);
    chk("one_wdata", imem_write_data, 32'h1234_5678);
`ifdef BOOT_CHECKSUM_EN
    send(8'h08, 0);
`else
    tick();
`endif
    chk("one_txv_lat", 32'(tx_valid), 32'd1);
    chk("one_txd", 32'(tx_data), 32'(BOOT_ACK));
    respond("one", BOOT_ACK, 0);
    exp_w.delete();
    exp_w.push_back(32'h1234_5678);
    check_writes("one", exp_w);

    send(BOOT_SYNC, 0);
    chk("reload_run", 32'(core_run), 32'd0);
    chk("reload_busy", 32'(boot_busy), 32'd1);
    load_frame("full", 64, 1'b1, 1, 1'b0, 10, 1'b0);

    send(BOOT_SYNC, 0);
    send(8'h02, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    c = 0;
    while (!tx_valid && c < TO + 20) begin
      tick();
      c++;
    end
    chk("to_lat", 32'(c), 32'(TO));
    respond("to", BOOT_NAK, 2);
    check_writes("to", none);

    bad_len("len0", 8'h00);
    bad_len("len65", 8'h41);

    load_frame("tail", 3, 1'b0, 2, 1'b1, 1, 1'b1);

    send(BOOT_SYNC, 0);
    send(8'h02, 0);
    send(8'hEF, 0);
    send(8'hBE, 0);
    send(8'hAD, 0);
    send(8'hDE, 0);
    send(8'h11, 0);
    rst = 1'b0;
    tick();
    chk("mid_run", 32'(core_run), 32'd0);
    chk("mid_txv", 32'(tx_valid), 32'd0);
    chk("mid_txd", 32'(tx_data), 32'd0);
    chk("mid_wen", 32'(imem_write_en), 32'd0);
    chk("mid_addr", 32'(imem_write_addr), 32'd0);
    chk("mid_wdata", imem_write_data, 32'd0);
    chk("mid_busy", 32'(boot_busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    exp_w.delete();
    exp_w.push_back(32'hDEAD_BEEF);
    check_writes("mid", exp_w);
    load_frame("post_rst", 2, 1'b0, 1, 1'b0, 1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      j = 8'($urandom_range(0, 255));
      if (j == BOOT_SYNC) j = 8'h54;
      send(j, 1);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) bad_len("rnd_len", 8'h00);
        else bad_len("rnd_len", 8'($urandom_range(65, 255)));
      end else begin
        load_frame("rnd", $urandom_range(1, 8), 1'b0, 2,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3), 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
